warp_multiskid: RTL and testbench

Parametrised multi-lane skid buffer placed between stages of the dual-issue (or wider) pipeline.
- Each cycle the producer writes 0..LANES entries and the consumer removes 0..LANES entries, strictly in order.
- Buffers instructions when a downstream stage consumes fewer than offered.
- Generalises the single-entry ready/valid skid to count-based handshakes with configurable lane count and depth.

---
 rtl/warp_multiskid.sv | 106 ++++++++++
 tb/tb_warp_multiskid.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/warp_multiskid.sv
// warp_multiskid: multi-lane skid buffer for a dual-issue (or wider) pipeline.
// Each cycle the producer writes up to LANES entries and the consumer removes
// up to LANES entries, strictly in order, through a DEPTH-entry circular store.
//
// Ports:
//   i_clk        clock
//   i_rst        asynchronous active-high reset
//   i_wcount     entries offered this cycle on lanes 0..i_wcount-1
//   i_wdata      write lanes, lane k = [k*WIDTH +: WIDTH]
//   o_wcapacity  entries the producer may write this cycle (registered)
//   o_rcount     valid entries on o_rdata, lanes 0..o_rcount-1
//   o_rdata      read lanes, lane 0 = oldest entry, unused lanes zero
//   i_rconsume   entries the consumer takes this cycle
module warp_multiskid #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(LANES + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [CW-1:0]          i_wcount,
    input  logic [LANES*WIDTH-1:0] i_wdata,
    output logic [CW-1:0]          o_wcapacity,
    output logic [CW-1:0]          o_rcount,
    output logic [LANES*WIDTH-1:0] o_rdata,
    input  logic [CW-1:0]          i_rconsume
);

    localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW       = $clog2(DEPTH + 1);
    localparam int unsigned WCAP_MAX = (LANES < DEPTH) ? LANES : DEPTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [OW-1:0]    space_d;
    logic [CW-1:0]    wcap_q, wcap_d;
    logic [CW-1:0]    rcount;
    logic [CW-1:0]    wr, rd;

    // Counts and next state. Capacity is derived from the post-update
    // occupancy and registered, so no input reaches an output combinationally.
    always_comb begin
        rcount  = (occ_q > OW'(LANES)) ? CW'(LANES) : CW'(occ_q);
        wr      = (i_wcount > wcap_q) ? wcap_q : i_wcount;
        rd      = (i_rconsume > rcount) ? rcount : i_rconsume;
        occ_d   = occ_q + OW'(wr) - OW'(rd);
        head_d  = PW'((32'(head_q) + 32'(rd)) % DEPTH);
        tail_d  = PW'((32'(tail_q) + 32'(wr)) % DEPTH);
        space_d = OW'(DEPTH) - occ_d;
        wcap_d  = (space_d > OW'(WCAP_MAX)) ? CW'(WCAP_MAX) : CW'(space_d);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            wcap_q <= CW'(WCAP_MAX);
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            wcap_q <= wcap_d;
        end
    end

    // Storage is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge i_clk) begin
        for (int unsigned k = 0; k < LANES; k++) begin
            if (k < 32'(wr)) begin
                mem_q[PW'((32'(tail_q) + k) % DEPTH)] <= i_wdata[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (k < 32'(rcount)) begin
                o_rdata[k*WIDTH +: WIDTH] = mem_q[PW'((32'(head_q) + k) % DEPTH)];
            end
        end
    end

    assign o_wcapacity = wcap_q;
    assign o_rcount    = rcount;

`ifdef WARP_FORMAL
    always_comb begin
        if (!i_rst) begin
            assert (32'(occ_q) <= DEPTH);
            assert (OW'(rcount) <= occ_q);
            assert (32'(wcap_q) + 32'(occ_q) <= DEPTH);
            assert (((32'(tail_q) - 32'(head_q)) % DEPTH) == (32'(occ_q) % DEPTH));
            cover (32'(occ_q) == DEPTH);
            cover (occ_q == '0);
            cover (32'(tail_q) + 32'(wr) >= DEPTH);
            cover ((wr != '0) && (rd != '0));
        end
    end
`endif

endmodule

// File: tb/tb_warp_multiskid.sv
module tb_warp_multiskid;

    localparam int W = 32;
    localparam int L = 2;
    localparam int D = 4;

    logic          clk;
    logic          rst;
    logic [1:0]    wcount;
    logic [63:0]   wdata;
    logic [1:0]    wcap;
    logic [1:0]    rcount;
    logic [63:0]   rdata;
    logic [1:0]    rconsume;

    int n_checks;
    int n_errors;

    // Reference model: the buffer contents as a plain FIFO queue.
    logic [31:0] q[$];
    logic [31:0] consumed[$];

    warp_multiskid #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wcount   (wcount),
        .i_wdata    (wdata),
        .o_wcapacity(wcap),
        .o_rcount   (rcount),
        .o_rdata    (rdata),
        .i_rconsume (rconsume)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int model_cap();
        return imin(L, D - q.size());
    endfunction

    function automatic int model_rcount();
        return imin(L, q.size());
    endfunction

    function automatic logic [31:0] model_lane(input int k);
        return (k < model_rcount()) ? q[k] : 32'h0;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ".wcap"},   32'(wcap),   32'(model_cap()));
        check_eq({tag, ".rcount"}, 32'(rcount), 32'(model_rcount()));
        check_eq({tag, ".lane0"},  rdata[31:0],  model_lane(0));
        check_eq({tag, ".lane1"},  rdata[63:32], model_lane(1));
    endtask

    // One clock cycle of traffic, entered and left just after a falling edge.
    task automatic cycle(input string tag, input int wc, input logic [31:0] d0,
                         input logic [31:0] d1, input int rc);
        int wr;
        int rd;
        wr = imin(wc, model_cap());
        rd = imin(rc, model_rcount());
        wcount   = 2'(wc);
        wdata    = {d1, d0};
        rconsume = 2'(rc);
        for (int k = 0; k < rd; k++) consumed.push_back(rdata[k*W +: W]);
        @(posedge clk);
        for (int k = 0; k < rd; k++) void'(q.pop_front());
        if (wr >= 1) q.push_back(d0);
        if (wr >= 2) q.push_back(d1);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic async_reset_check(input string tag);
        rst = 1'b1;
        q.delete();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        wcount   = '0;
        wdata    = '0;
        rconsume = '0;

        @(negedge clk);
        check_outputs("por");
        rst = 1'b0;

        // Reset asserted mid-cycle with data buffered.
        cycle("prefill", 2, 32'hAA, 32'hBB, 0);
        #2;
        async_reset_check("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b0;

        // Directed sequence.
        cycle("wr_AB", 2, 32'h11, 32'h22, 0);
        cycle("wr_CD", 2, 32'h33, 32'h44, 0);
        cycle("full_ignore", 2, 32'h55, 32'h55, 0);
        cycle("consume1", 0, 32'h0, 32'h0, 1);
        cycle("clamp_wr", 2, 32'h55, 32'h66, 2);

        // Drain, then stream 1-in/1-out so pointers wrap.
        cycle("drain", 0, 32'h0, 32'h0, 2);
        consumed.delete();
        for (int v = 1; v <= 10; v++) cycle("stream", 1, 32'(v), 32'h0, 1);
        cycle("stream_end", 0, 32'h0, 32'h0, 1);
        check_eq("stream.count", 32'(consumed.size()), 32'd10);
        for (int i = 0; i < consumed.size() && i < 10; i++)
            check_eq("stream.order", consumed[i], 32'(i + 1));

        // Reset with occ = 3, then a lone write.
        cycle("occ3a", 2, 32'hA1, 32'hA2, 0);
        cycle("occ3b", 1, 32'hA3, 32'h0, 0);
        async_reset_check("rst_occ3");
        @(negedge clk);
        check_outputs("rst_occ3_hold");
        rst = 1'b0;
        cycle("post_rst", 1, 32'h77, 32'hDEAD, 0);

        // Randomised traffic, including over-requests and occasional resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset_check("rnd_rst");
                @(negedge clk);
                rst = 1'b0;
            end else begin
                cycle("rnd", int'($urandom_range(0, 3)), $urandom, $urandom,
                      int'($urandom_range(0, 3)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
